// File: rtl/lstm_ctrl_pkg.sv
// ============================================================================
// Module  : lstm_ctrl_pkg
// Brief   : Shared sizing helpers and FSM encoding for the input-hidden
//           sequencer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package lstm_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    function automatic int calc_nchunk(input int in_size, input int parall);
        return (in_size + parall - 1) / parall;
    endfunction

    // A full last chunk yields REM = PARALL_NUM, so nothing gets masked.
    function automatic int calc_rem(input int in_size, input int parall);
        return in_size - (calc_nchunk(in_size, parall) - 1) * parall;
    endfunction

    function automatic int calc_rows(input int hidden);
        return 4 * hidden;
    endfunction

    function automatic int clog2w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int calc_accw(input int qz, input int parall, input int nchunk);
        return 2 * qz + clog2w(parall * nchunk);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ih_lane_sum.sv
// ============================================================================
// Module  : ih_lane_sum
// Brief   : Masks tail lanes of a row's last chunk, sign-extends and sums.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module ih_lane_sum #(
    parameter int PARALL_NUM = 10,
    parameter int QZ         = 24,
    parameter int REM        = 10,
    parameter int SW         = 52
) (
    input  logic [PARALL_NUM*2*QZ-1:0] lanes,
    input  logic                       last_chunk,
    output logic signed [SW-1:0]       sum
);

    localparam int PW = 2 * QZ;

    logic [PW-1:0] lane_m [PARALL_NUM];

    for (genvar i = 0; i < PARALL_NUM; i++) begin : g_lane
        if (i >= REM) begin : g_mask
            assign lane_m[i] = last_chunk ? '0 : lanes[i*PW +: PW];
        end else begin : g_pass
            assign lane_m[i] = lanes[i*PW +: PW];
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < PARALL_NUM; i++) begin
            sum = sum + {{(SW-PW){lane_m[i][PW-1]}}, lane_m[i]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/ih_seq_ctrl.sv
// ============================================================================
// Module  : ih_seq_ctrl
// Brief   : Issues (row, chunk) reads for the input-hidden product and
//           accumulates returned lane products into per-row totals.
//           Define IH_SEQ_SAT_EN for saturating outputs with a sticky flag.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module ih_seq_ctrl
    import lstm_ctrl_pkg::*;
#(
    parameter  int INPUT_SIZE  = 128,
    parameter  int HIDDEN_SIZE = 32,
    parameter  int PARALL_NUM  = 10,
    parameter  int QZ          = 24,
    parameter  int MULT_LAT    = 5,
    localparam int NCHUNK      = calc_nchunk(INPUT_SIZE, PARALL_NUM),
    localparam int REM         = calc_rem(INPUT_SIZE, PARALL_NUM),
    localparam int ROWS        = calc_rows(HIDDEN_SIZE),
    localparam int CW          = clog2w(NCHUNK),
    localparam int WW          = clog2w(ROWS * NCHUNK),
    localparam int RW          = clog2w(ROWS),
    localparam int AW          = calc_accw(QZ, PARALL_NUM, NCHUNK),
    localparam int OW          = 2 * QZ
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [CW-1:0]              in_rd_addr,
    output logic [WW-1:0]              w_rd_addr,
    output logic                       mac_valid,
    input  logic [PARALL_NUM*2*QZ-1:0] mult_in,
    input  logic                       mult_valid,
    output logic [OW-1:0]              acc_out,
    output logic                       acc_valid,
    output logic [RW-1:0]              acc_row,
    output logic                       sat_flag
);

    localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);
    localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);
    localparam logic [RW:0]   ALL_ROWS   = (RW+1)'(ROWS);

    state_t               state_q, state_d;
    logic [CW-1:0]        chunk_q, chunk_d;
    logic [RW-1:0]        row_q, row_d;
    logic [WW-1:0]        waddr_q, waddr_d;
    logic [CW-1:0]        rchunk_q, rchunk_d;
    logic [RW:0]          rrow_q, rrow_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [OW-1:0]        acc_out_q, acc_out_d;
    logic [RW-1:0]        acc_row_q, acc_row_d;
    logic                 acc_valid_q, acc_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 mac_valid_q, mac_valid_d;
    logic                 sat_q, sat_d;

    logic                 w_ret_last;
    logic signed [AW-1:0] w_lane_sum;
    logic signed [AW-1:0] w_row_total;
    logic [OW-1:0]        w_out;
    logic                 w_clamp;

    assign w_ret_last  = (rchunk_q == LAST_CHUNK);
    assign w_row_total = acc_q + w_lane_sum;

    ih_lane_sum #(
        .PARALL_NUM (PARALL_NUM),
        .QZ         (QZ),
        .REM        (REM),
        .SW         (AW)
    ) u_lane_sum (
        .lanes      (mult_in),
        .last_chunk (w_ret_last),
        .sum        (w_lane_sum)
    );

`ifdef IH_SEQ_SAT_EN
    localparam logic signed [AW-1:0] OUT_MAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] OUT_MIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    always_comb begin
        w_out   = w_row_total[OW-1:0];
        w_clamp = 1'b0;
        if (w_row_total > OUT_MAX) begin
            w_out   = OUT_MAX[OW-1:0];
            w_clamp = 1'b1;
        end else if (w_row_total < OUT_MIN) begin
            w_out   = OUT_MIN[OW-1:0];
            w_clamp = 1'b1;
        end
    end
`else
    assign w_out   = w_row_total[OW-1:0];
    assign w_clamp = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        chunk_d     = chunk_q;
        row_d       = row_q;
        waddr_d     = waddr_q;
        rchunk_d    = rchunk_q;
        rrow_d      = rrow_q;
        acc_d       = acc_q;
        acc_out_d   = acc_out_q;
        acc_row_d   = acc_row_q;
        acc_valid_d = 1'b0;
        sat_d       = sat_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_ISSUE;
                    chunk_d  = '0;
                    row_d    = '0;
                    waddr_d  = '0;
                    rchunk_d = '0;
                    rrow_d   = '0;
                    acc_d    = '0;
                    sat_d    = 1'b0;
                end
            end
            S_ISSUE: begin
                waddr_d = waddr_q + WW'(1);
                if (chunk_q == LAST_CHUNK) begin
                    chunk_d = '0;
                    if (row_q == LAST_ROW) begin
                        state_d = S_DRAIN;
                        row_d   = '0;
                        waddr_d = '0;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end else begin
                    chunk_d = chunk_q + CW'(1);
                end
            end
            S_DRAIN: begin
                if (rrow_q == ALL_ROWS) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Return path runs on its own counters; products seen in IDLE are stale.
        if (state_q != S_IDLE && mult_valid) begin
            if (w_ret_last) begin
                acc_out_d   = w_out;
                acc_valid_d = 1'b1;
                acc_row_d   = rrow_q[RW-1:0];
                acc_d       = '0;
                rchunk_d    = '0;
                rrow_d      = rrow_q + (RW+1)'(1);
                sat_d       = sat_q | w_clamp;
            end else begin
                acc_d    = w_row_total;
                rchunk_d = rchunk_q + CW'(1);
            end
        end
    end

    assign busy_d      = (state_d != S_IDLE);
    assign done_d      = (state_d == S_FIN);
    assign mac_valid_d = (state_q == S_ISSUE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            chunk_q     <= '0;
            row_q       <= '0;
            waddr_q     <= '0;
            rchunk_q    <= '0;
            rrow_q      <= '0;
            acc_q       <= '0;
            acc_out_q   <= '0;
            acc_row_q   <= '0;
            acc_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mac_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            chunk_q     <= chunk_d;
            row_q       <= row_d;
            waddr_q     <= waddr_d;
            rchunk_q    <= rchunk_d;
            rrow_q      <= rrow_d;
            acc_q       <= acc_d;
            acc_out_q   <= acc_out_d;
            acc_row_q   <= acc_row_d;
            acc_valid_q <= acc_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mac_valid_q <= mac_valid_d;
            sat_q       <= sat_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign in_rd_addr = chunk_q;
    assign w_rd_addr  = waddr_q;
    assign mac_valid  = mac_valid_q;
    assign acc_out    = acc_out_q;
    assign acc_valid  = acc_valid_q;
    assign acc_row    = acc_row_q;
    assign sat_flag   = sat_q;

endmodule

`default_nettype wire

// File: tb/tb_ih_seq_ctrl.sv
// ============================================================================
// Module  : tb_ih_seq_ctrl
// Brief   : Directed bench for ih_seq_ctrl across three sizings with a
//           fixed-latency product model.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_ih_seq_ctrl;

    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic [15:0] lane_v = 16'd1;
    logic [159:0] lanes;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          st_cyc = 0;

    assign lanes = {10{lane_v}};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: 20 inputs, 1 hidden -> 2 chunks, 4 rows
    logic        busy_a, done_a, mac_valid_a, acc_valid_a, sat_a, mult_valid_a;
    logic [0:0]  in_addr_a;
    logic [2:0]  w_addr_a;
    logic [15:0] acc_out_a;
    logic [1:0]  acc_row_a;
    logic [LAT-1:0] pipe_a = '0;
    assign mult_valid_a = pipe_a[LAT-1];
    always @(posedge clk) pipe_a <= {pipe_a[LAT-2:0], mac_valid_a};

    ih_seq_ctrl #(.INPUT_SIZE(20), .HIDDEN_SIZE(1), .PARALL_NUM(10), .QZ(8), .MULT_LAT(LAT)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
        .in_rd_addr(in_addr_a), .w_rd_addr(w_addr_a), .mac_valid(mac_valid_a),
        .mult_in(lanes), .mult_valid(mult_valid_a), .acc_out(acc_out_a),
        .acc_valid(acc_valid_a), .acc_row(acc_row_a), .sat_flag(sat_a)
    );

    // DUT B: 25 inputs -> 3 chunks, last chunk keeps 5 lanes
    logic        busy_b, done_b, mac_valid_b, acc_valid_b, sat_b, mult_valid_b;
    logic [1:0]  in_addr_b;
    logic [3:0]  w_addr_b;
    logic [15:0] acc_out_b;
    logic [1:0]  acc_row_b;
    logic [LAT-1:0] pipe_b = '0;
    assign mult_valid_b = pipe_b[LAT-1];
    always @(posedge clk) pipe_b <= {pipe_b[LAT-2:0], mac_valid_b};

    ih_seq_ctrl #(.INPUT_SIZE(25), .HIDDEN_SIZE(1), .PARALL_NUM(10), .QZ(8), .MULT_LAT(LAT)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .in_rd_addr(in_addr_b), .w_rd_addr(w_addr_b), .mac_valid(mac_valid_b),
        .mult_in(lanes), .mult_valid(mult_valid_b), .acc_out(acc_out_b),
        .acc_valid(acc_valid_b), .acc_row(acc_row_b), .sat_flag(sat_b)
    );

    // DUT C: 30 inputs, 2 hidden -> 3 chunks, 8 rows
    logic        busy_c, done_c, mac_valid_c, acc_valid_c, sat_c, mult_valid_c;
    logic [1:0]  in_addr_c;
    logic [4:0]  w_addr_c;
    logic [15:0] acc_out_c;
    logic [2:0]  acc_row_c;
    logic [LAT-1:0] pipe_c = '0;
    assign mult_valid_c = pipe_c[LAT-1];
    always @(posedge clk) pipe_c <= {pipe_c[LAT-2:0], mac_valid_c};

    ih_seq_ctrl #(.INPUT_SIZE(30), .HIDDEN_SIZE(2), .PARALL_NUM(10), .QZ(8), .MULT_LAT(LAT)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .busy(busy_c), .done(done_c),
        .in_rd_addr(in_addr_c), .w_rd_addr(w_addr_c), .mac_valid(mac_valid_c),
        .mult_in(lanes), .mult_valid(mult_valid_c), .acc_out(acc_out_c),
        .acc_valid(acc_valid_c), .acc_row(acc_row_c), .sat_flag(sat_c)
    );

    // Event logs, indexed by monotonic counters
    int          nacc_a = 0, nacc_b = 0, nacc_c = 0;
    int          nmac_a = 0, nmac_c = 0;
    int          ndone_a = 0, ndone_b = 0, ndone_c = 0;
    logic [15:0] accbuf_a [64], accbuf_b [64], accbuf_c [64];
    logic [7:0]  rowbuf_a [64], rowbuf_b [64], rowbuf_c [64];
    int          acccyc_a = 0;
    int          maccyc_a [64], maccyc_c [64];
    logic [7:0]  waddrbuf_c [64], iaddrbuf_c [64];
    logic [7:0]  prev_w_c = '0, prev_i_c = '0;

    always @(negedge clk) begin
        if (acc_valid_a) begin
            accbuf_a[nacc_a % 64] <= acc_out_a;
            rowbuf_a[nacc_a % 64] <= 8'(acc_row_a);
            acccyc_a              <= cyc;
            nacc_a                <= nacc_a + 1;
        end
        if (acc_valid_b) begin
            accbuf_b[nacc_b % 64] <= acc_out_b;
            rowbuf_b[nacc_b % 64] <= 8'(acc_row_b);
            nacc_b                <= nacc_b + 1;
        end
        if (acc_valid_c) begin
            accbuf_c[nacc_c % 64] <= acc_out_c;
            rowbuf_c[nacc_c % 64] <= 8'(acc_row_c);
            nacc_c                <= nacc_c + 1;
        end
        if (mac_valid_a) begin
            maccyc_a[nmac_a % 64] <= cyc;
            nmac_a                <= nmac_a + 1;
        end
        if (mac_valid_c) begin
            maccyc_c[nmac_c % 64]   <= cyc;
            waddrbuf_c[nmac_c % 64] <= prev_w_c;
            iaddrbuf_c[nmac_c % 64] <= prev_i_c;
            nmac_c                  <= nmac_c + 1;
        end
        prev_w_c <= 8'(w_addr_c);
        prev_i_c <= 8'(in_addr_c);
        if (done_a) ndone_a <= ndone_a + 1;
        if (done_b) ndone_b <= ndone_b + 1;
        if (done_c) ndone_c <= ndone_c + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input int sel);
        @(posedge clk); #1;
        case (sel)
            0: start_a = 1'b1;
            1: start_b = 1'b1;
            default: start_c = 1'b1;
        endcase
        st_cyc = cyc;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    task automatic wait_done(input int sel, input int base, input int budget);
        int  n;
        bit  seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            n = (sel == 0) ? ndone_a : (sel == 1) ? ndone_b : ndone_c;
            if (n > base) seen = 1'b1;
        end
        check_eq("done_seen", 32'(seen), 32'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_rows(input int sel, input int base, input int nrows, input logic [15:0] exp);
        for (int r = 0; r < nrows; r++) begin
            case (sel)
                0: begin
                    check_eq("acc_out_a", 32'(accbuf_a[(base + r) % 64]), 32'(exp));
                    check_eq("acc_row_a", 32'(rowbuf_a[(base + r) % 64]), 32'(r));
                end
                1: begin
                    check_eq("acc_out_b", 32'(accbuf_b[(base + r) % 64]), 32'(exp));
                    check_eq("acc_row_b", 32'(rowbuf_b[(base + r) % 64]), 32'(r));
                end
                default: begin
                    check_eq("acc_out_c", 32'(accbuf_c[(base + r) % 64]), 32'(exp));
                    check_eq("acc_row_c", 32'(rowbuf_c[(base + r) % 64]), 32'(r));
                end
            endcase
        end
    endtask

    task automatic check_issue_c(input int base_mac);
        check_eq("mac_run_len_c", 32'(maccyc_c[(base_mac + 23) % 64] - maccyc_c[base_mac % 64]), 32'd23);
        for (int i = 0; i < 24; i++) begin
            check_eq("w_rd_addr_c", 32'(waddrbuf_c[(base_mac + i) % 64]), 32'(i));
            check_eq("in_rd_addr_c", 32'(iaddrbuf_c[(base_mac + i) % 64]), 32'(i % 3));
        end
    endtask

    initial begin
        int b_acc, b_done, b_mac;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy_a), 32'd0);
        check_eq("rst_done", 32'(done_a), 32'd0);
        check_eq("rst_mac_valid", 32'(mac_valid_a), 32'd0);
        check_eq("rst_acc_valid", 32'(acc_valid_a), 32'd0);
        check_eq("rst_acc_out", 32'(acc_out_a), 32'd0);
        check_eq("rst_sat", 32'(sat_a), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic pass: 2 full chunks of ones -> 20 per row
        lane_v = 16'd1;
        b_acc = nacc_a; b_done = ndone_a; b_mac = nmac_a;
        pulse_start(0);
        check_eq("busy_after_start", 32'(busy_a), 32'd1);
        wait_done(0, b_done, 200);
        check_eq("acc_count_a", 32'(nacc_a - b_acc), 32'd4);
        check_rows(0, b_acc, 4, 16'd20);
        check_eq("done_count_a", 32'(ndone_a - b_done), 32'd1);
        check_eq("mac_count_a", 32'(nmac_a - b_mac), 32'd8);
        check_eq("start_to_mac", 32'(maccyc_a[b_mac % 64] - st_cyc), 32'd2);
        check_eq("mac_to_acc", 32'(acccyc_a - maccyc_a[(b_mac + 7) % 64]), 32'(LAT + 1));
        check_eq("busy_idle_a", 32'(busy_a), 32'd0);

        // Remainder masking: lanes 5..9 of the last chunk dropped
        b_acc = nacc_b; b_done = ndone_b;
        pulse_start(1);
        wait_done(1, b_done, 200);
        check_eq("acc_count_b", 32'(nacc_b - b_acc), 32'd4);
        check_rows(1, b_acc, 4, 16'd25);

        // Same with -1 products: exercises sign extension
        lane_v = 16'hFFFF;
        b_acc = nacc_b; b_done = ndone_b;
        pulse_start(1);
        wait_done(1, b_done, 200);
        check_rows(1, b_acc, 4, 16'hFFE7);
        lane_v = 16'd1;

        // Issue order on 8 rows x 3 chunks
        b_acc = nacc_c; b_done = ndone_c; b_mac = nmac_c;
        pulse_start(2);
        wait_done(2, b_done, 300);
        check_eq("mac_count_c", 32'(nmac_c - b_mac), 32'd24);
        check_issue_c(b_mac);
        check_rows(2, b_acc, 8, 16'd30);

        // Second start mid-ISSUE is ignored
        b_acc = nacc_c; b_done = ndone_c; b_mac = nmac_c;
        pulse_start(2);
        repeat (6) @(posedge clk);
        pulse_start(2);
        wait_done(2, b_done, 300);
        check_eq("mac_count_c2", 32'(nmac_c - b_mac), 32'd24);
        check_issue_c(b_mac);
        check_eq("done_count_c2", 32'(ndone_c - b_done), 32'd1);
        check_eq("acc_count_c2", 32'(nacc_c - b_acc), 32'd8);

        // Reset during DRAIN
        b_done = ndone_a;
        pulse_start(0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", 32'(busy_a), 32'd0);
        check_eq("mid_rst_mac_valid", 32'(mac_valid_a), 32'd0);
        check_eq("mid_rst_acc_valid", 32'(acc_valid_a), 32'd0);
        check_eq("mid_rst_acc_out", 32'(acc_out_a), 32'd0);
        check_eq("mid_rst_acc_row", 32'(acc_row_a), 32'd0);
        check_eq("mid_rst_w_addr", 32'(w_addr_a), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check_eq("no_done_after_rst", 32'(ndone_a - b_done), 32'd0);
        b_acc = nacc_a; b_done = ndone_a;
        pulse_start(0);
        wait_done(0, b_done, 200);
        check_eq("acc_count_after_rst", 32'(nacc_a - b_acc), 32'd4);
        check_rows(0, b_acc, 4, 16'd20);

        // Overflowing rows: 20 x 0x7FFF
        lane_v = 16'h7FFF;
        b_acc = nacc_a; b_done = ndone_a;
        pulse_start(0);
        wait_done(0, b_done, 200);
`ifdef IH_SEQ_SAT_EN
        check_rows(0, b_acc, 4, 16'h7FFF);
        check_eq("sat_flag_set", 32'(sat_a), 32'd1);
`else
        check_rows(0, b_acc, 4, 16'hFFEC);
        check_eq("sat_flag_tied", 32'(sat_a), 32'd0);
`endif
        // Sticky flag clears on the next start
        lane_v = 16'd1;
        b_done = ndone_a;
        pulse_start(0);
        check_eq("sat_clear_on_start", 32'(sat_a), 32'd0);
        wait_done(0, b_done, 200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
